// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 set-2 key decoder: prefix/error codes, the game's
// scan codes, key bit indices and FSM state encoding.
package ps2_kbd_pkg;

    localparam int unsigned NUM_KEYS = 12;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;
    // Only valid after an E0 prefix
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_UP    = 4'd4;
    localparam logic [3:0] KEY_DOWN  = 4'd5;
    localparam logic [3:0] KEY_LEFT  = 4'd6;
    localparam logic [3:0] KEY_RIGHT = 4'd7;
    localparam logic [3:0] KEY_SPACE = 4'd8;
    localparam logic [3:0] KEY_ENTER = 4'd9;
    localparam logic [3:0] KEY_ESC   = 4'd10;
    localparam logic [3:0] KEY_P     = 4'd11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

endpackage

// File: rtl/ps2_code_lookup.sv
// Combinational map from (scan code, extended flag) to the game key index.
module ps2_code_lookup
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    output logic       hit_o,
    output logic [3:0] idx_o
);

    always_comb begin
        hit_o = 1'b1;
        idx_o = KEY_W;
        if (ext_i) begin
            case (code_i)
                SC_UP:    idx_o = KEY_UP;
                SC_DOWN:  idx_o = KEY_DOWN;
                SC_LEFT:  idx_o = KEY_LEFT;
                SC_RIGHT: idx_o = KEY_RIGHT;
                default:  hit_o = 1'b0;
            endcase
        end else begin
            case (code_i)
                SC_W:     idx_o = KEY_W;
                SC_A:     idx_o = KEY_A;
                SC_S:     idx_o = KEY_S;
                SC_D:     idx_o = KEY_D;
                SC_SPACE: idx_o = KEY_SPACE;
                SC_ENTER: idx_o = KEY_ENTER;
                SC_ESC:   idx_o = KEY_ESC;
                SC_P:     idx_o = KEY_P;
                default:  hit_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte parser: tracks held state of the game keys and emits a press/release
// event only when a held flag actually changes.
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                key_evt,
    output logic [3:0]          evt_idx,
    output logic                evt_make,
    output logic                kbd_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                evt_q, evt_d;
    logic [3:0]          idx_q, idx_d;
    logic                make_q, make_d;
    logic                err_q, err_d;

    logic       is_ext, is_brk;
    logic       lk_hit;
    logic [3:0] lk_idx;

    assign is_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_code_lookup u_lookup (
        .code_i (scan_code),
        .ext_i  (is_ext),
        .hit_o  (lk_hit),
        .idx_o  (lk_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        evt_d   = 1'b0;
        idx_d   = idx_q;
        make_d  = make_q;
        err_d   = 1'b0;

        if (flush) begin
            key_d   = '0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (scan_valid) begin
            cnt_d = '0;
            if (scan_code == SC_ERR_LO || scan_code == SC_ERR_HI) begin
                key_d   = '0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (scan_code == SC_EXT) begin
                if (state_q == ST_IDLE) state_d = ST_EXT;
                else if (state_q == ST_BRK) state_d = ST_EXT_BRK;
            end else if (scan_code == SC_BRK) begin
                if (state_q == ST_IDLE) state_d = ST_BRK;
                else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
            end else begin
                state_d = ST_IDLE;
                // Typematic repeats and stray breaks leave the flag as-is and stay silent
                if (lk_hit && !is_brk && !key_q[lk_idx]) begin
                    key_d[lk_idx] = 1'b1;
                    evt_d         = 1'b1;
                    idx_d         = lk_idx;
                    make_d        = 1'b1;
                end else if (lk_hit && is_brk && key_q[lk_idx]) begin
                    key_d[lk_idx] = 1'b0;
                    evt_d         = 1'b1;
                    idx_d         = lk_idx;
                    make_d        = 1'b0;
                end
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            evt_q   <= 1'b0;
            idx_q   <= '0;
            make_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            evt_q   <= evt_d;
            idx_q   <= idx_d;
            make_q  <= make_d;
            err_q   <= err_d;
        end
    end

    assign key_state = key_q;
    assign key_evt   = evt_q;
    assign evt_idx   = idx_q;
    assign evt_make  = make_q;
    assign kbd_err   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a shortened sequence timeout.
module tb_ps2_key_decoder;

    localparam int unsigned T = 20;

    logic        clk;
    logic        clr_n;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        flush;
    logic [11:0] key_state;
    logic        key_evt;
    logic [3:0]  evt_idx;
    logic        evt_make;
    logic        kbd_err;

    int n_vec = 0;
    int n_err = 0;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .flush      (flush),
        .key_state  (key_state),
        .key_evt    (key_evt),
        .evt_idx    (evt_idx),
        .evt_make   (evt_make),
        .kbd_err    (kbd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte sampled on the next rising edge; outputs observed 1 ns later
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_evt(input string tag, input logic e, input logic [3:0] i,
                           input logic m, input logic [11:0] ks);
        chk({tag, ".evt"}, {31'd0, key_evt}, {31'd0, e});
        if (e) begin
            chk({tag, ".idx"}, {28'd0, evt_idx}, {28'd0, i});
            chk({tag, ".make"}, {31'd0, evt_make}, {31'd0, m});
        end
        chk({tag, ".ks"}, {20'd0, key_state}, {20'd0, ks});
    endtask

    initial begin
        clr_n      = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        flush      = 1'b0;
        #23;
        chk("rst.ks", {20'd0, key_state}, 32'h0);
        chk("rst.evt", {31'd0, key_evt}, 32'h0);
        chk("rst.idx", {28'd0, evt_idx}, 32'h0);
        chk("rst.make", {31'd0, evt_make}, 32'h0);
        chk("rst.err", {31'd0, kbd_err}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;

        // W press then release
        send(8'h1D); chk_evt("w_make", 1, 4'd0, 1, 12'h001);
        idle(1);     chk("w_pulse_end", {31'd0, key_evt}, 32'h0);
        send(8'hF0); chk_evt("w_f0", 0, 4'd0, 0, 12'h001);
        send(8'h1D); chk_evt("w_brk", 1, 4'd0, 0, 12'h000);

        // Up with typematic repeats, then extended break
        send(8'hE0); send(8'h75); chk_evt("up_make", 1, 4'd4, 1, 12'h010);
        send(8'hE0); send(8'h75); chk_evt("up_rep1", 0, 4'd0, 0, 12'h010);
        send(8'hE0); send(8'h75); chk_evt("up_rep2", 0, 4'd0, 0, 12'h010);
        chk("up_idx_hold", {28'd0, evt_idx}, 32'd4);
        send(8'hE0); send(8'hF0); send(8'h75); chk_evt("up_brk", 1, 4'd4, 0, 12'h000);

        // Space, Enter, then keyboard error
        send(8'h29); chk_evt("space", 1, 4'd8, 1, 12'h100);
        send(8'h5A); chk_evt("enter", 1, 4'd9, 1, 12'h300);
        send(8'hFF); chk_evt("ff", 0, 4'd0, 0, 12'h000);
        chk("ff.err", {31'd0, kbd_err}, 32'h1);
        idle(1);     chk("ff.err_end", {31'd0, kbd_err}, 32'h0);

        // Error 00 mid-prefix drops the prefix
        send(8'hE0); send(8'h00);
        chk("e0_00.err", {31'd0, kbd_err}, 32'h1);
        send(8'h75); chk_evt("e0_00_then_75", 0, 4'd0, 0, 12'h000);

        // Sequence timeout, then normal decode of A
        send(8'hE0);
        idle(T);     chk("to.before", {31'd0, kbd_err}, 32'h0);
        idle(1);     chk("to.fire", {31'd0, kbd_err}, 32'h1);
        chk("to.ks", {20'd0, key_state}, 32'h0);
        idle(1);     chk("to.end", {31'd0, kbd_err}, 32'h0);
        send(8'h1C); chk_evt("to.a_make", 1, 4'd1, 1, 12'h002);

        // Byte on the timeout cycle wins and keeps the extended prefix
        send(8'hE0);
        idle(T);
        send(8'h75); chk_evt("to_race.up", 1, 4'd4, 1, 12'h012);
        chk("to_race.err", {31'd0, kbd_err}, 32'h0);
        idle(2);     chk("to_race.err_late", {31'd0, kbd_err}, 32'h0);
        send(8'hE0); send(8'hF0); send(8'h75); chk_evt("up_brk2", 1, 4'd4, 0, 12'h002);
        send(8'hF0); send(8'h1C); chk_evt("a_brk", 1, 4'd1, 0, 12'h000);

        // Unmapped codes and stray break
        send(8'h15); chk_evt("unm_15", 0, 4'd0, 0, 12'h000);
        send(8'hE0); send(8'h15); chk_evt("unm_e0_15", 0, 4'd0, 0, 12'h000);
        send(8'h1D); chk_evt("after_e0_15", 1, 4'd0, 1, 12'h001);
        send(8'hF0); send(8'h1D); chk_evt("w_brk2", 1, 4'd0, 0, 12'h000);
        send(8'hF0); send(8'h23); chk_evt("stray_brk_d", 0, 4'd0, 0, 12'h000);
        send(8'h23); chk_evt("d_make", 1, 4'd3, 1, 12'h008);

        // Flush beats simultaneous byte
        @(negedge clk);
        flush      = 1'b1;
        scan_code  = 8'h1D;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        scan_valid = 1'b0;
        chk_evt("flush", 0, 4'd0, 0, 12'h000);
        chk("flush.idx_hold", {28'd0, evt_idx}, 32'd3);
        chk("flush.make_hold", {31'd0, evt_make}, 32'd1);

        // Reset between E0 and 75 drops the prefix
        send(8'hE0);
        @(negedge clk);
        clr_n = 1'b0;
        idle(2);
        @(negedge clk);
        clr_n = 1'b1;
        send(8'h75); chk_evt("rst_mid", 0, 4'd0, 0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
